// File: rtl/line_buf_ctrl_if.sv
// Pixel-timing bus between the delayed line-buffer taps and the window sequencer.
// The master drives the delayed dv/hs/vs; the slave returns position and status.
interface line_buf_ctrl_if #(
  parameter int unsigned COL_W = 11,
  parameter int unsigned ROW_W = 11
);
  logic             dv_i;
  logic             hs_i;
  logic             vs_i;
  logic             dv_o;
  logic             hs_o;
  logic             vs_o;
  logic [COL_W-1:0] col_o;
  logic [ROW_W-1:0] row_o;
  logic [2:0]       row_valid_o;
  logic             win_valid_o;
  logic [COL_W-1:0] line_len_o;
  logic [ROW_W-1:0] frame_lines_o;
  logic             len_err_o;
  logic             ovf_err_o;
  logic             sof_o;

  modport master (
    output dv_i, hs_i, vs_i,
    input  dv_o, hs_o, vs_o, col_o, row_o, row_valid_o, win_valid_o,
    input  line_len_o, frame_lines_o, len_err_o, ovf_err_o, sof_o
  );

  modport slave (
    input  dv_i, hs_i, vs_i,
    output dv_o, hs_o, vs_o, col_o, row_o, row_valid_o, win_valid_o,
    output line_len_o, frame_lines_o, len_err_o, ovf_err_o, sof_o
  );
endinterface

// File: rtl/line_buf_ctrl.sv
// Frame/line sequencer for the 3-row window: tracks pixel position, masks stale
// previous-frame rows, measures frame geometry and flags line-length errors.
module line_buf_ctrl #(
  parameter int unsigned COL_W       = 11,
  parameter int unsigned ROW_W       = 11,
  parameter int unsigned SCREENWIDTH = 1600,
  parameter bit          VS_POL      = 1'b1
) (
  input logic            clk,
  input logic            rst,
  line_buf_ctrl_if.slave bus
);

  localparam logic [COL_W-1:0] ColMax  = '1;
  localparam logic [ROW_W-1:0] RowMax  = '1;
  localparam logic [COL_W-1:0] ScreenW = COL_W'(SCREENWIDTH);

  typedef enum logic [1:0] {StSync, StFirst, StLine, StGap} state_e;

  state_e           state_q, state_d, cur_st;
  logic             vs_q, hs_q, dv_q, dv_d;
  logic [COL_W-1:0] col_q, col_d, line_len_q, line_len_d, col_inc, len_cur;
  logic [ROW_W-1:0] row_q, row_d, frame_lines_q, frame_lines_d, row_inc;
  logic [2:0]       row_valid_q, row_valid_d;
  logic             win_valid_q, win_valid_d;
  logic             len_err_q, len_err_d, ovf_err_q, ovf_err_d, sof_q, sof_d;
  logic             vs_edge;

  assign vs_edge = (bus.vs_i == VS_POL) && (vs_q != VS_POL);
  assign col_inc = (col_q == ColMax) ? ColMax : col_q + COL_W'(1);
  assign row_inc = (row_q == RowMax) ? RowMax : row_q + ROW_W'(1);
  // Length of the line just ended is last column + 1, saturating like the column.
  assign len_cur = col_inc;

  always_comb begin
    state_d       = state_q;
    cur_st        = state_q;
    dv_d          = 1'b0;
    col_d         = col_q;
    row_d         = row_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    len_err_d     = 1'b0;
    ovf_err_d     = 1'b0;
    sof_d         = 1'b0;

    // Frame start is resolved first so a coincident pixel lands on row 0, col 0.
    if (vs_edge) begin
      sof_d = 1'b1;
      if (state_q == StLine) begin
        frame_lines_d = row_inc;
      end else if (state_q == StGap) begin
        frame_lines_d = row_q;
      end else if (state_q == StFirst) begin
        frame_lines_d = '0;
      end
      cur_st = StFirst;
      col_d  = '0;
      row_d  = '0;
    end
    state_d = cur_st;

    unique case (cur_st)
      StSync: ;
      StFirst, StGap: begin
        if (bus.dv_i) begin
          state_d = StLine;
          dv_d    = 1'b1;
          col_d   = '0;
        end
      end
      StLine: begin
        if (bus.dv_i) begin
          dv_d  = 1'b1;
          col_d = col_inc;
          if (col_q != ColMax && col_inc == ScreenW) begin
            ovf_err_d = 1'b1;
          end
        end else begin
          state_d = StGap;
          col_d   = '0;
          row_d   = row_inc;
          if (row_q == '0) begin
            line_len_d = len_cur;
          end else if (len_cur != line_len_q) begin
            len_err_d = 1'b1;
          end
        end
      end
    endcase

    row_valid_d = {dv_d & (row_d > ROW_W'(1)), dv_d & (row_d != '0), dv_d};
    win_valid_d = dv_d & (row_d > ROW_W'(1)) & (col_d > COL_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StSync;
      vs_q          <= 1'b0;
      hs_q          <= 1'b0;
      dv_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      row_valid_q   <= '0;
      win_valid_q   <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      len_err_q     <= 1'b0;
      ovf_err_q     <= 1'b0;
      sof_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= bus.vs_i;
      hs_q          <= bus.hs_i;
      dv_q          <= dv_d;
      col_q         <= col_d;
      row_q         <= row_d;
      row_valid_q   <= row_valid_d;
      win_valid_q   <= win_valid_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      len_err_q     <= len_err_d;
      ovf_err_q     <= ovf_err_d;
      sof_q         <= sof_d;
    end
  end

  assign bus.dv_o          = dv_q;
  assign bus.hs_o          = hs_q;
  assign bus.vs_o          = vs_q;
  assign bus.col_o         = col_q;
  assign bus.row_o         = row_q;
  assign bus.row_valid_o   = row_valid_q;
  assign bus.win_valid_o   = win_valid_q;
  assign bus.line_len_o    = line_len_q;
  assign bus.frame_lines_o = frame_lines_q;
  assign bus.len_err_o     = len_err_q;
  assign bus.ovf_err_o     = ovf_err_q;
  assign bus.sof_o         = sof_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: directed frames plus random frames, every output checked
// each cycle against a pixel/line counting model of the sequencer.
module tb_line_buf_ctrl;
  localparam int unsigned COL_W       = 4;
  localparam int unsigned ROW_W       = 3;
  localparam int unsigned SCREENWIDTH = 8;
  localparam bit          VS_POL      = 1'b1;
  localparam int          COL_MAX     = (1 << COL_W) - 1;
  localparam int          ROW_MAX     = (1 << ROW_W) - 1;
  localparam bit          VS_ON       = VS_POL;
  localparam bit          VS_OFF      = !VS_POL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_buf_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  line_buf_ctrl #(
    .COL_W      (COL_W),
    .ROW_W      (ROW_W),
    .SCREENWIDTH(SCREENWIDTH),
    .VS_POL     (VS_POL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame membership, pixel index in the run, lines finished.
  bit m_synced, m_vs_prev, m_in_run;
  int m_col, m_lines;
  int e_dv, e_hs, e_vs, e_col, e_row, e_rv, e_win;
  int e_line_len, e_frame_lines, e_len_err, e_ovf, e_sof;

  int win_cnt, sof_cnt, len_err_cnt, ovf_cnt, col_peak;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit dv, input bit hs, input bit vs);
    bit vs_rise;
    int len;
    if (r) begin
      m_synced = 1'b0; m_vs_prev = 1'b0; m_in_run = 1'b0; m_col = 0; m_lines = 0;
      e_dv = 0; e_hs = 0; e_vs = 0; e_col = 0; e_row = 0; e_line_len = 0;
      e_frame_lines = 0; e_len_err = 0; e_ovf = 0; e_sof = 0;
    end else begin
      vs_rise   = (vs == VS_POL) && (m_vs_prev != VS_POL);
      m_vs_prev = vs;
      e_hs      = hs;
      e_vs      = vs;
      e_sof     = vs_rise;
      e_len_err = 0;
      e_ovf     = 0;
      if (vs_rise) begin
        if (m_synced) e_frame_lines = imin(m_lines + (m_in_run ? 1 : 0), ROW_MAX);
        m_synced = 1'b1; m_lines = 0; m_in_run = 1'b0; m_col = 0;
      end
      e_dv = (m_synced && dv) ? 1 : 0;
      if (m_synced) begin
        if (dv) begin
          m_col = m_in_run ? m_col + 1 : 0;
          if (m_in_run && m_col == SCREENWIDTH) e_ovf = 1;
          m_in_run = 1'b1;
        end else if (m_in_run) begin
          len = imin(m_col + 1, COL_MAX);
          if (m_lines == 0) e_line_len = len;
          else if (len != e_line_len) e_len_err = 1;
          m_lines++;
          m_in_run = 1'b0;
        end
      end
      e_col = e_dv ? imin(m_col, COL_MAX) : 0;
      e_row = imin(m_lines, ROW_MAX);
    end
    e_rv  = e_dv ? (1 + ((e_row >= 1) ? 2 : 0) + ((e_row >= 2) ? 4 : 0)) : 0;
    e_win = (e_dv && e_row >= 2 && e_col >= 2) ? 1 : 0;
  endtask

  task automatic compare_all();
    check_val("dv_o", bus.dv_o, e_dv);
    check_val("hs_o", bus.hs_o, e_hs);
    check_val("vs_o", bus.vs_o, e_vs);
    check_val("col_o", bus.col_o, e_col);
    check_val("row_o", bus.row_o, e_row);
    check_val("row_valid_o", bus.row_valid_o, e_rv);
    check_val("win_valid_o", bus.win_valid_o, e_win);
    check_val("line_len_o", bus.line_len_o, e_line_len);
    check_val("frame_lines_o", bus.frame_lines_o, e_frame_lines);
    check_val("len_err_o", bus.len_err_o, e_len_err);
    check_val("ovf_err_o", bus.ovf_err_o, e_ovf);
    check_val("sof_o", bus.sof_o, e_sof);
    if (bus.win_valid_o === 1'b1) win_cnt++;
    if (bus.sof_o === 1'b1) sof_cnt++;
    if (bus.len_err_o === 1'b1) len_err_cnt++;
    if (bus.ovf_err_o === 1'b1) ovf_cnt++;
    if (bus.dv_o === 1'b1 && int'(bus.col_o) > col_peak) col_peak = int'(bus.col_o);
  endtask

  task automatic clear_cnts();
    win_cnt = 0; sof_cnt = 0; len_err_cnt = 0; ovf_cnt = 0; col_peak = 0;
  endtask

  task automatic step(input bit r, input bit dv, input bit vs);
    bit hs;
    hs = 1'($urandom);
    rst = r; bus.dv_i = dv; bus.hs_i = hs; bus.vs_i = vs;
    model_step(r, dv, hs, vs);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_line(input int len, input int gap);
    for (int i = 0; i < len; i++) step(1'b0, 1'b1, VS_OFF);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0, VS_OFF);
  endtask

  task automatic vs_start();
    step(1'b0, 1'b0, VS_ON);
    step(1'b0, 1'b0, VS_ON);
    step(1'b0, 1'b0, VS_OFF);
  endtask

  initial begin
    bit carry, cut;
    int base, nl, len, gap;
    rst = 1'b1; bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = VS_OFF;
    clear_cnts();
    step(1'b1, 1'b0, VS_OFF);
    step(1'b1, 1'b1, VS_OFF);

    // dv without any vs edge is ignored
    send_line(4, 2);
    send_line(3, 2);
    check_val("nosync_sof_cnt", sof_cnt, 0);

    // Four 6-pixel lines
    clear_cnts();
    vs_start();
    for (int l = 0; l < 4; l++) send_line(6, 3);
    check_val("frame_sof_cnt", sof_cnt, 1);
    check_val("frame_win_cnt", win_cnt, 8);
    check_val("frame_line_len", bus.line_len_o, 6);
    step(1'b0, 1'b0, VS_ON);
    check_val("frame_lines_4", bus.frame_lines_o, 4);
    step(1'b0, 1'b0, VS_OFF);

    // Short row 2
    clear_cnts();
    send_line(6, 3); send_line(6, 3); send_line(5, 3); send_line(6, 3);
    check_val("short_len_err_cnt", len_err_cnt, 1);

    // Overflow past SCREENWIDTH
    clear_cnts();
    vs_start();
    send_line(10, 3);
    check_val("ovf_cnt", ovf_cnt, 1);
    check_val("ovf_col_peak", col_peak, 9);

    // vs edge together with dv mid-line at row 1, col 3
    clear_cnts();
    vs_start();
    send_line(6, 3);
    send_line(3, 0);
    step(1'b0, 1'b1, VS_ON);
    check_val("cut_sof", bus.sof_o, 1);
    check_val("cut_frame_lines", bus.frame_lines_o, 2);
    check_val("cut_col", bus.col_o, 0);
    check_val("cut_row", bus.row_o, 0);
    send_line(5, 3);
    check_val("cut_len_err_cnt", len_err_cnt, 0);

    // Reset during row 2, then dv ignored until a vs edge
    vs_start();
    send_line(6, 2); send_line(6, 2); send_line(3, 0);
    step(1'b1, 1'b1, VS_OFF);
    check_val("rst_dv", bus.dv_o, 0);
    clear_cnts();
    send_line(6, 2); send_line(6, 2);
    check_val("rst_ignored_sof", sof_cnt, 0);
    check_val("rst_ignored_len_err", len_err_cnt, 0);

    // Random frames
    carry = 1'b0;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 19) == 0) begin
        step(1'b1, 1'($urandom), VS_OFF);
        carry = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom), VS_OFF);
      end
      step(1'b0, carry, VS_ON);
      if (!carry && $urandom_range(0, 1) == 1) step(1'b0, 1'b0, VS_ON);
      carry = 1'b0;
      cut   = 1'b0;
      base  = $urandom_range(1, 18);
      nl    = $urandom_range(0, 10);
      for (int l = 0; l < nl && !cut; l++) begin
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : base;
        gap = $urandom_range(1, 3);
        for (int p = 0; p < len && !cut; p++) begin
          if (p > 0 && $urandom_range(0, 59) == 0) begin
            cut   = 1'b1;
            carry = 1'b1;
          end else begin
            step(1'b0, 1'b1, VS_OFF);
          end
        end
        if (!cut) for (int i = 0; i < gap; i++) step(1'b0, 1'b0, VS_OFF);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
- Frame/line sequencer for the 3-row line-buffer window path in the HDMI pipeline. Sits beside the line buffer and takes the buffer's delayed dv/hs/vs.
- Tracks pixel column and row, and says which of the three window rows hold valid current-frame data. This masks stale last-frame rows at the top of each image.
- Flags when the full 3x3 window is populated, measures frame geometry and reports line-length errors.

Parameters:
- COL_W, 11, column counter / line-length width
- ROW_W, 11, row counter / frame-height width
- SCREENWIDTH, 1600, max legal pixels per line
- VS_POL, 1, active level of vs_i (1 = active-high)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dv_i  in  1  data valid, aligned with window row 0 pixel
- hs_i  in  1  hsync (passed through only)
- vs_i  in  1  vsync
- dv_o  out  1  dv_i delayed 1 cycle, forced 0 in SYNC state
- hs_o  out  1  hs_i delayed 1 cycle
- vs_o  out  1  vs_i delayed 1 cycle
- col_o  out  COL_W  column index of the pixel on dv_o
- row_o  out  ROW_W  row index of the pixel on dv_o
- row_valid_o  out  3  bit k = window row k holds current-frame data
- win_valid_o  out  1  full 3x3 window valid
- line_len_o  out  COL_W  length of row 0 of the current frame
- frame_lines_o  out  ROW_W  row count of the last completed frame
- len_err_o  out  1  1-cycle pulse: line length differs from line_len_o
- ovf_err_o  out  1  1-cycle pulse: line exceeds SCREENWIDTH
- sof_o  out  1  1-cycle pulse on detected frame start

Behaviour:
- Reset: all outputs 0, counters 0, state SYNC. Reset mid-frame discards the frame; no error pulses are raised.
- All outputs are registered. Latency is 1 cycle from the *_i inputs.
- Vs edge: the inactive-to-active transition of vs_i, with active = VS_POL, detected against a registered copy of vs_i.
- States:
  - SYNC: dv ignored, dv_o=0. Vs edge -> FIRST.
  - FIRST: row counter=0. dv_i=1 -> LINE.
  - LINE: dv_i=0 -> GAP.
  - GAP: dv_i=1 -> LINE.
  - From FIRST/LINE/GAP, a vs edge -> FIRST.
  - On a vs edge from LINE or GAP: frame_lines_o <= rows completed (a LINE in progress counts as completed), sof_o=1.
  - On a vs edge from FIRST: frame_lines_o <= 0, sof_o=1.
  - A vs edge coincident with dv_i=1 is processed as frame start first; that pixel becomes row 0, col 0.
- Column counter:
  - 0 on the first dv_i=1 cycle of a line, +1 per dv cycle.
  - Saturates at 2^COL_W-1.
  - Reset to 0 when dv falls.
- Row counter:
  - +1 on each LINE->GAP transition, i.e. on dv_i falling.
  - Saturates at 2^ROW_W-1.
  - Cleared by a vs edge.
- row_valid_o:
  - bit0 = dv_o
  - bit1 = dv_o & (row_o >= 1)
  - bit2 = dv_o & (row_o >= 2)
- win_valid_o = dv_o & row_o >= 2 & col_o >= 2.
- line_len_o:
  - Latched with the final column+1 at the end of row 0.
  - Holds its value until the end of row 0 of the next frame.
- len_err_o:
  - Pulses in the cycle after dv falls on any row >= 1 whose length != line_len_o.
  - Not raised for row 0.
- ovf_err_o:
  - Pulses once, in the cycle col_o would reach SCREENWIDTH.
  - Counting continues after the pulse.
- A line truncated by a vs edge is not length-checked.
- Single-pixel lines (dv high 1 cycle) are legal: LINE->GAP the next cycle, length 1.

Test Plan:
- Reset, then dv pulses with no vs edge -> dv_o stays 0, all counters 0, no error pulses.
- Vs edge, then 4 lines of 6 pixels with 3-cycle gaps:
  - sof_o pulses once; line_len_o=6.
  - row_valid_o = 001 on row 0, 011 on row 1, 111 on rows 2-3.
  - win_valid_o high at cols 2-5 of rows 2-3 (8 cycles total).
  - Next vs edge -> frame_lines_o=4.
- Row 2 with 5 pixels in a 6-pixel frame -> len_err_o pulses once, 1 cycle after dv falls; other rows give no pulse.
- SCREENWIDTH=8, line of 10 pixels -> ovf_err_o pulses once at col 8; col_o reaches 9.
- Vs edge mid-line (row 1, col 3), asserted together with dv_i:
  - sof_o=1, frame_lines_o=2.
  - The coincident pixel is row 0, col 0; no len_err_o.
- rst asserted during row 2 -> outputs 0 next cycle, state SYNC; subsequent dv is ignored until a vs edge.
